pll_lock_detect: RTL and testbench

//  Consumes the PLL phase-error stream (o_err of the CORDIC PLL, strobed by its phase-detect done).

---
 rtl/pll_lock_pkg.sv | 24 ++
 rtl/pll_lock_winavg.sv | 87 ++++++++
 rtl/pll_lock_detect.sv | 130 +++++++++++++
 tb/tb_pll_lock_detect.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_pkg.sv
// Shared types and helpers for the PLL lock detector.
package pll_lock_pkg;

    localparam int unsigned LGWIN_W = 4;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

    // |x| for a w-bit signed value, saturating the most negative code to 2^(w-1)-1
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
        logic [31:0] maxv;
        logic [31:0] mag;
        maxv = (32'd1 << (w - 1)) - 32'd1;
        mag  = (x < 0) ? 32'(-x) : 32'(x);
        if (mag > maxv) begin
            mag = maxv;
        end
        return mag;
    endfunction

endpackage

// File: rtl/pll_lock_winavg.sv
// Windowed mean of |err|: abs stage, accumulator, sample counter and power-of-two divide.
module pll_lock_winavg
    import pll_lock_pkg::*;
#(
    parameter int unsigned EW     = 16,
    parameter int unsigned LGWMAX = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_ce,
    input  logic signed [EW-1:0]      i_err,
    input  logic [LGWIN_W-1:0]        i_lgwin,
    output logic [EW-2:0]             o_avg,
    output logic                      o_stb
);

    localparam int unsigned AW = EW + LGWMAX;
    localparam int unsigned CW = LGWMAX + 1;

    logic [EW-2:0]      abs_q, abs_d;
    logic               ce_dly_q, ce_dly_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LGWIN_W-1:0] lgw_q, lgw_d;
    logic [EW-2:0]      avg_q, avg_d;
    logic               stb_q, stb_d;

    logic [LGWIN_W-1:0] lgwin_clamped;
    logic [LGWIN_W-1:0] lg_eff;
    logic [AW-1:0]      sum;

    always_comb begin
        abs_d    = abs_q;
        ce_dly_d = i_ce;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        lgw_d    = lgw_q;
        avg_d    = avg_q;
        stb_d    = 1'b0;

        if (i_ce) begin
            abs_d = (EW-1)'(sat_abs(32'(i_err), EW));
        end

        // Window length is taken from the input only on a window's first sample
        lgwin_clamped = (i_lgwin > LGWIN_W'(LGWMAX)) ? LGWIN_W'(LGWMAX) : i_lgwin;
        lg_eff        = (cnt_q == '0) ? lgwin_clamped : lgw_q;
        sum           = ((cnt_q == '0) ? '0 : acc_q) + AW'(abs_q);

        if (ce_dly_q) begin
            lgw_d = lg_eff;
            if (cnt_q == ((CW'(1) << lg_eff) - CW'(1))) begin
                avg_d = (EW-1)'(sum >> lg_eff);
                stb_d = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            abs_q    <= '0;
            ce_dly_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            lgw_q    <= '0;
            avg_q    <= '0;
            stb_q    <= 1'b0;
        end else begin
            abs_q    <= abs_d;
            ce_dly_q <= ce_dly_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            lgw_q    <= lgw_d;
            avg_q    <= avg_d;
            stb_q    <= stb_d;
        end
    end

    assign o_avg = avg_q;
    assign o_stb = stb_q;

endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock detector: windowed mean |phase error| feeding a hysteretic lock state machine.
module pll_lock_detect
    import pll_lock_pkg::*;
#(
    parameter int unsigned EW     = 16,
    parameter int unsigned LGWMAX = 8,
    parameter int unsigned NGOOD  = 4,
    parameter int unsigned NBAD   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic signed [EW-1:0]  i_err,
    input  logic [3:0]            i_lgwin,
    input  logic [EW-2:0]         i_lock_thresh,
    input  logic [EW-2:0]         i_unlock_thresh,
    output logic [EW-2:0]         o_avg_err,
    output logic                  o_avg_stb,
    output logic                  o_locked,
    output logic                  o_lock_chg
);

    localparam int unsigned GW = $clog2(NGOOD + 1);
    localparam int unsigned BW = $clog2(NBAD + 1);

    lock_state_e   state_q, state_d;
    logic [GW-1:0] good_q, good_d, good_inc;
    logic [BW-1:0] bad_q, bad_d, bad_inc;
    logic          locked_q, locked_d;
    logic          chg_q, chg_d;

    logic [EW-2:0] avg;
    logic          avg_stb;

    pll_lock_winavg #(
        .EW     (EW),
        .LGWMAX (LGWMAX)
    ) u_winavg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_err   (i_err),
        .i_lgwin (i_lgwin),
        .o_avg   (avg),
        .o_stb   (avg_stb)
    );

    // Lock FSM advances once per completed window
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        bad_d    = bad_q;
        good_inc = good_q + GW'(1);
        bad_inc  = bad_q + BW'(1);

        if (avg_stb) begin
            unique case (state_q)
                ST_UNLOCKED: begin
                    if (avg <= i_lock_thresh) begin
                        if (NGOOD <= 1) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            state_d = ST_ACQUIRE;
                            good_d  = GW'(1);
                        end
                    end
                end
                ST_ACQUIRE: begin
                    if (avg <= i_lock_thresh) begin
                        if (good_inc == GW'(NGOOD)) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_inc;
                        end
                    end else begin
                        state_d = ST_UNLOCKED;
                        good_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (avg > i_unlock_thresh) begin
                        if (bad_inc == BW'(NBAD)) begin
                            state_d = ST_UNLOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
        chg_d    = locked_d ^ locked_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_UNLOCKED;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            chg_q    <= chg_d;
        end
    end

    assign o_avg_err  = avg;
    assign o_avg_stb  = avg_stb;
    assign o_locked   = locked_q;
    assign o_lock_chg = chg_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Bench for pll_lock_detect: directed tables/sequences plus randomized run against a window-level model.
module tb_pll_lock_detect;

    localparam int EW    = 16;
    localparam int NGOOD = 4;
    localparam int NBAD  = 2;

    logic               clk = 1'b0;
    logic               i_reset;
    logic               i_ce;
    logic signed [15:0] i_err;
    logic [3:0]         i_lgwin;
    logic [14:0]        i_lock_thresh;
    logic [14:0]        i_unlock_thresh;
    logic [14:0]        o_avg_err;
    logic               o_avg_stb;
    logic               o_locked;
    logic               o_lock_chg;

    always #5 clk = ~clk;

    pll_lock_detect #(
        .EW     (16),
        .LGWMAX (8),
        .NGOOD  (NGOOD),
        .NBAD   (NBAD)
    ) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_ce            (i_ce),
        .i_err           (i_err),
        .i_lgwin         (i_lgwin),
        .i_lock_thresh   (i_lock_thresh),
        .i_unlock_thresh (i_unlock_thresh),
        .o_avg_err       (o_avg_err),
        .o_avg_stb       (o_avg_stb),
        .o_locked        (o_locked),
        .o_lock_chg      (o_lock_chg)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: windows are queues of |err|, lock is good/bad window counting
    int  q_win[$];
    int  win_lg   = 0;
    bit  pend_v   = 0;
    int  pend_abs = 0;
    bit  m_stb    = 0;
    int  m_avg    = 0;
    bit  m_locked = 0;
    bit  m_chg    = 0;
    int  m_good   = 0;
    int  m_bad    = 0;

    function automatic int ref_abs(input int e);
        int a;
        a = (e < 0) ? -e : e;
        return (a > 32767) ? 32767 : a;
    endfunction

    task automatic model_step();
        int s;
        if (i_reset) begin
            q_win.delete();
            pend_v = 0; m_stb = 0; m_avg = 0; m_locked = 0; m_chg = 0;
            m_good = 0; m_bad = 0;
        end else begin
            m_chg = 0;
            if (m_stb) begin
                if (!m_locked) begin
                    if (m_avg <= int'(i_lock_thresh)) begin
                        m_good++;
                        if (m_good >= NGOOD) begin
                            m_locked = 1; m_good = 0; m_bad = 0; m_chg = 1;
                        end
                    end else m_good = 0;
                end else begin
                    if (m_avg > int'(i_unlock_thresh)) begin
                        m_bad++;
                        if (m_bad >= NBAD) begin
                            m_locked = 0; m_good = 0; m_bad = 0; m_chg = 1;
                        end
                    end else m_bad = 0;
                end
            end
            m_stb = 0;
            if (pend_v) begin
                if (q_win.size() == 0) win_lg = (int'(i_lgwin) > 8) ? 8 : int'(i_lgwin);
                q_win.push_back(pend_abs);
                if (q_win.size() == (1 << win_lg)) begin
                    s = q_win.sum();
                    m_avg = s >> win_lg;
                    m_stb = 1;
                    q_win.delete();
                end
            end
            pend_v   = i_ce;
            pend_abs = ref_abs(int'(i_err));
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle-by-cycle comparison of all outputs against the model
    initial forever begin
        int act, exp;
        @(negedge clk);
        act = (int'(o_avg_stb) << 17) | (int'(o_locked) << 16) | (int'(o_lock_chg) << 15) | int'(o_avg_err);
        exp = (int'(m_stb) << 17) | (int'(m_locked) << 16) | (int'(m_chg) << 15) | m_avg;
        check("model", act, exp);
    end

    task automatic step(input bit ce, input int err);
        i_ce  = ce;
        i_err = 16'(err);
        @(negedge clk);
    endtask

    typedef struct {
        int err;
        int exp_avg;
    } vec_t;

    vec_t tbl[8];
    int   mag;

    initial begin
        tbl[0] = '{5, 5};        tbl[1] = '{-7, 7};
        tbl[2] = '{3, 3};        tbl[3] = '{-32768, 32767};
        tbl[4] = '{32767, 32767}; tbl[5] = '{0, 0};
        tbl[6] = '{-1, 1};       tbl[7] = '{-32767, 32767};

        i_reset = 1'b1; i_ce = 1'b0; i_err = '0; i_lgwin = 4'd2;
        i_lock_thresh = 15'd200; i_unlock_thresh = 15'd500;
        step(0, 0); step(0, 0);
        check("rst_avg", int'(o_avg_err), 0);
        check("rst_stb", int'(o_avg_stb), 0);
        check("rst_locked", int'(o_locked), 0);
        check("rst_chg", int'(o_lock_chg), 0);
        i_reset = 1'b0;

        // Four good windows of +/-100 acquire lock
        for (int i = 0; i < 16; i++) step(1, (i % 2 == 1) ? -100 : 100);
        check("t1_not_yet", int'(o_locked), 0);
        step(0, 0);
        check("t1_stb", int'(o_avg_stb), 1);
        check("t1_avg", int'(o_avg_err), 100);
        check("t1_locked_n2", int'(o_locked), 0);
        step(0, 0);
        check("t1_locked", int'(o_locked), 1);
        check("t1_chg", int'(o_lock_chg), 1);
        step(0, 0);
        check("t1_chg_pulse", int'(o_lock_chg), 0);

        // One bad window then a good one keeps lock; two bad windows drop it
        for (int i = 0; i < 4; i++) step(1, 1000);
        for (int i = 0; i < 4; i++) step(1, 100);
        for (int i = 0; i < 8; i++) step(1, 1000);
        check("t2_hold", int'(o_locked), 1);
        step(0, 0);
        check("t2_avg", int'(o_avg_err), 1000);
        check("t2_still", int'(o_locked), 1);
        step(0, 0);
        check("t2_unlock", int'(o_locked), 0);
        check("t2_chg", int'(o_lock_chg), 1);

        // Saturated error never locks
        i_lock_thresh = 15'd32766;
        for (int i = 0; i < 8; i++) step(1, -32768);
        step(0, 0);
        check("t3_sat_avg", int'(o_avg_err), 32767);
        step(0, 0);
        check("t3_no_lock", int'(o_locked), 0);

        // Single-sample windows, back to back
        i_lgwin = 4'd0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) step(1, tbl[i].err);
            else step(0, 0);
            if (i >= 1) begin
                check("t4_stb", int'(o_avg_stb), 1);
                check("t4_avg", int'(o_avg_err), tbl[i-1].exp_avg);
            end
        end
        step(0, 0);

        // Reset mid-window while locked
        i_lgwin = 4'd2; i_lock_thresh = 15'd200;
        for (int i = 0; i < 16; i++) step(1, 50);
        step(0, 0); step(0, 0); step(0, 0);
        check("t5_locked", int'(o_locked), 1);
        step(1, 50); step(1, 50);
        i_reset = 1'b1;
        step(1, 50);
        check("t5_rst_avg", int'(o_avg_err), 0);
        check("t5_rst_locked", int'(o_locked), 0);
        check("t5_rst_stbchg", int'(o_avg_stb) | int'(o_lock_chg), 0);
        i_reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 300);
        step(0, 0);
        check("t5_fresh_stb", int'(o_avg_stb), 1);
        check("t5_fresh_avg", int'(o_avg_err), 300);

        // lgwin change mid-window takes effect on the next window
        step(1, 40); step(1, 40);
        i_lgwin = 4'd3;
        step(1, 40); step(1, 40);
        step(1, 80);
        check("t6_w4_stb", int'(o_avg_stb), 1);
        check("t6_w4_avg", int'(o_avg_err), 40);
        for (int i = 0; i < 4; i++) step(1, 80);
        check("t6_no_short", int'(o_avg_stb), 0);
        for (int i = 0; i < 3; i++) step(1, 80);
        step(0, 0);
        check("t6_w8_stb", int'(o_avg_stb), 1);
        check("t6_w8_avg", int'(o_avg_err), 80);

        // Randomized traffic checked cycle by cycle against the model
        mag = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: mag = 50;
                    1: mag = 300;
                    2: mag = 1000;
                    default: mag = 32768;
                endcase
            end
            if ($urandom_range(0, 49) == 0) i_lgwin = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) i_lgwin = 4'($urandom_range(9, 15));
            if ($urandom_range(0, 199) == 0) begin
                i_lock_thresh   = ($urandom_range(0, 1) == 1) ? 15'd200 : 15'd400;
                i_unlock_thresh = ($urandom_range(0, 1) == 1) ? 15'd500 : 15'd150;
            end
            i_reset = ($urandom_range(0, 599) == 0);
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 2 * mag)) - mag);
        end
        i_reset = 1'b0;
        step(0, 0); step(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
